intersection_sequencer: RTL and testbench

- Two-approach intersection controller that sequences the main-road and side-road lamp sets, plus a pedestrian walk phase.
- Rests on main green. Serves latched side-road vehicle and pedestrian requests, with yellow and all-red clearance between conflicting phases.
- Sits above the per-approach lamp drivers. Its lamp outputs are the only source of lamp state for both approaches.

---
 rtl/intersection_sequencer.sv | 146 ++++++++++++++
 tb/tb_intersection_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_sequencer.sv
// Two-approach intersection controller: main road rests on green, side-road
// vehicle and pedestrian requests are latched and served in turn with yellow
// and all-red clearance between conflicting phases. Lamps are a Moore decode
// of the state register, so no input reaches a lamp combinationally.
module intersection_sequencer #(
  parameter int TW              = 8,
  parameter int MIN_GREEN_TIME  = 12,
  parameter int YELLOW_TIME     = 3,
  parameter int ALLRED_TIME     = 2,
  parameter int SIDE_GREEN_TIME = 8,
  parameter int WALK_TIME       = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_sensor,
  input  logic       ped_button,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       side_pending,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_AR1  = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4,
    S_AR2  = 3'd5,
    S_WALK = 3'd6
  } state_t;

  // Last timer value of each dwell; a dwell of T cycles expires at T-1.
  localparam logic [TW-1:0] MG_LAST     = TW'(MIN_GREEN_TIME - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_TIME - 1);
  localparam logic [TW-1:0] SG_LAST     = TW'(SIDE_GREEN_TIME - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(WALK_TIME - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            side_q, side_d;
  logic            ped_q, ped_d;

  // State, dwell timer and request latches; reset drops any phase in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_MG;
      timer_q <= '0;
      side_q  <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      side_q  <= side_d;
      ped_q   <= ped_d;
    end
  end

  // Next state, timer and latch update.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MG:   if (timer_q == MG_LAST && (side_q || ped_q)) state_d = S_MY;
      S_MY:   if (timer_q == YELLOW_LAST) state_d = S_AR1;
      S_AR1:  if (timer_q == ALLRED_LAST) state_d = ped_q ? S_WALK : S_SG;
      S_SG:   if (timer_q == SG_LAST) state_d = S_SY;
      S_SY:   if (timer_q == YELLOW_LAST) state_d = S_AR2;
      S_WALK: if (timer_q == WALK_LAST) state_d = S_AR2;
      S_AR2:  if (timer_q == ALLRED_LAST) state_d = S_MG;
      default: state_d = S_AR2;
    endcase

    // Main green holds its timer at the last value so a late request is
    // served on the very next edge and the counter can never wrap.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_MG && timer_q == MG_LAST) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // A request present on the edge that starts its service is absorbed by
    // that service rather than re-latched.
    if (state_d == S_SG && state_q != S_SG) begin
      side_d = 1'b0;
    end else begin
      side_d = side_q | side_sensor;
    end
    if (state_d == S_WALK && state_q != S_WALK) begin
      ped_d = 1'b0;
    end else begin
      ped_d = ped_q | ped_button;
    end
  end

  // Lamp decode from the registered state only; unknown codes show all-red.
  always_comb begin
    main_red    = 1'b0;
    main_yellow = 1'b0;
    main_green  = 1'b0;
    side_red    = 1'b0;
    side_yellow = 1'b0;
    side_green  = 1'b0;
    walk        = 1'b0;
    case (state_q)
      S_MG: begin
        main_green = 1'b1;
        side_red   = 1'b1;
      end
      S_MY: begin
        main_yellow = 1'b1;
        side_red    = 1'b1;
      end
      S_SG: begin
        main_red   = 1'b1;
        side_green = 1'b1;
      end
      S_SY: begin
        main_red    = 1'b1;
        side_yellow = 1'b1;
      end
      S_WALK: begin
        main_red = 1'b1;
        side_red = 1'b1;
        walk     = 1'b1;
      end
      default: begin
        main_red = 1'b1;
        side_red = 1'b1;
      end
    endcase
  end

  assign side_pending = side_q;
  assign ped_pending  = ped_q;
  assign phase        = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Bench for intersection_sequencer: a cycle model pushes the expected state
// of every cycle onto a scoreboard queue as stimulus is driven; the entry is
// popped and compared once the DUT has taken the edge. Phase run lengths are
// additionally checked against fixed numbers for the main scenarios.
module tb_intersection_sequencer;

  localparam int TW  = 8;
  localparam int MGT = 12;
  localparam int YT  = 3;
  localparam int ART = 2;
  localparam int SGT = 8;
  localparam int WT  = 6;

  localparam int P_MG = 0, P_MY = 1, P_AR1 = 2, P_SG = 3, P_SY = 4, P_AR2 = 5, P_WALK = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_sensor = 1'b0;
  logic       ped_button = 1'b0;
  logic       main_red, main_yellow, main_green;
  logic       side_red, side_yellow, side_green;
  logic       walk, side_pending, ped_pending;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] lamps;
    logic       sp;
    logic       pp;
  } exp_t;

  exp_t sbq[$];
  int   plog[$];
  int   exp_codes[$];
  int   exp_lens[$];
  bit   logging = 1'b0;

  // Reference model state: phase plus cycles left before the dwell expires.
  int m_state = P_MG;
  int m_left  = MGT - 1;
  bit m_side  = 1'b0;
  bit m_ped   = 1'b0;

  intersection_sequencer #(
    .TW(TW), .MIN_GREEN_TIME(MGT), .YELLOW_TIME(YT), .ALLRED_TIME(ART),
    .SIDE_GREEN_TIME(SGT), .WALK_TIME(WT)
  ) dut (
    .clk(clk), .rst(rst), .side_sensor(side_sensor), .ped_button(ped_button),
    .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
    .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
    .walk(walk), .side_pending(side_pending), .ped_pending(ped_pending),
    .phase(phase)
  );

  always #5 clk = ~clk;

  // Safety invariants on every cycle out of reset.
  assert property (@(posedge clk) disable iff (rst)
    ($onehot({main_red, main_yellow, main_green}) &&
     $onehot({side_red, side_yellow, side_green}) &&
     !(main_green && side_green) &&
     (!walk || (main_red && side_red))))
  else begin
    errors++;
    $display("FAIL invariant: main=%b side=%b walk=%b", {main_red, main_yellow, main_green},
             {side_red, side_yellow, side_green}, walk);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
    end
  endtask

  function automatic int dwell(input int st);
    case (st)
      P_MG:   return MGT;
      P_MY:   return YT;
      P_SY:   return YT;
      P_SG:   return SGT;
      P_WALK: return WT;
      default: return ART;
    endcase
  endfunction

  // {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}
  function automatic logic [6:0] lamp_table(input int st);
    case (st)
      P_MG:   return 7'b001_100_0;
      P_MY:   return 7'b010_100_0;
      P_SG:   return 7'b100_001_0;
      P_SY:   return 7'b100_010_0;
      P_WALK: return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit p);
    int  nxt;
    bit  done;
    exp_t e;
    if (r) begin
      m_state = P_MG;
      m_left  = MGT - 1;
      m_side  = 1'b0;
      m_ped   = 1'b0;
    end else begin
      done = (m_left == 0);
      nxt  = m_state;
      if (done) begin
        case (m_state)
          P_MG:   if (m_side || m_ped) nxt = P_MY;
          P_MY:   nxt = P_AR1;
          P_AR1:  nxt = m_ped ? P_WALK : P_SG;
          P_SG:   nxt = P_SY;
          P_SY:   nxt = P_AR2;
          P_WALK: nxt = P_AR2;
          default: nxt = P_MG;
        endcase
      end
      m_side = (nxt == P_SG && m_state != P_SG) ? 1'b0 : (m_side | s);
      m_ped  = (nxt == P_WALK && m_state != P_WALK) ? 1'b0 : (m_ped | p);
      if (nxt != m_state) m_left = dwell(nxt) - 1;
      else if (m_left > 0) m_left = m_left - 1;
      m_state = nxt;
    end
    e.ph    = 3'(m_state);
    e.lamps = lamp_table(m_state);
    e.sp    = m_side;
    e.pp    = m_ped;
    sbq.push_back(e);
  endtask

  task automatic step(input bit r, input bit s, input bit p);
    exp_t e;
    rst = r;
    side_sensor = s;
    ped_button = p;
    model_edge(r, s, p);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("phase", 32'(phase), 32'(e.ph));
    check("lamps", 32'({main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk}),
          32'(e.lamps));
    check("side_pending", 32'(side_pending), 32'(e.sp));
    check("ped_pending", 32'(ped_pending), 32'(e.pp));
    if (logging) plog.push_back(int'(phase));
  endtask

  task automatic do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic start_log();
    plog.delete();
    plog.push_back(int'(phase));
    logging = 1'b1;
  endtask

  // Compare the leading phase runs of the log against exp_codes/exp_lens.
  task automatic check_runs(input string tag);
    int rc[$];
    int rl[$];
    logging = 1'b0;
    foreach (plog[i]) begin
      if (rc.size() == 0 || rc[rc.size()-1] != plog[i]) begin
        rc.push_back(plog[i]);
        rl.push_back(1);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    check({tag, "_enough_runs"}, 32'(rc.size() > exp_codes.size()), 32'd1);
    foreach (exp_codes[i]) begin
      if (i < rc.size()) begin
        check($sformatf("%s_code%0d", tag, i), 32'(rc[i]), 32'(exp_codes[i]));
        check($sformatf("%s_len%0d", tag, i), 32'(rl[i]), 32'(exp_lens[i]));
      end
    end
  endtask

  // Advance idle until the model reaches (state, cycles left); bounded.
  task automatic run_until(input int st, input int left, input bit s, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_state == st && m_left == left) begin
        hit = 1'b1;
        break;
      end
      step(0, s, 0);
    end
    check({tag, "_reached"}, 32'(hit), 32'd1);
  endtask

  initial begin
    // Idle: main green indefinitely with no requests.
    do_reset();
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_main_green", 32'(main_green), 32'd1);
    check("reset_side_red", 32'(side_red), 32'd1);
    idle(100);
    check("idle_phase", 32'(phase), 32'd0);

    // Side service with a 1-cycle pulse early in main green.
    do_reset();
    start_log();
    idle(2);
    step(0, 1, 0);
    idle(37);
    exp_codes = {P_MG, P_MY, P_AR1, P_SG, P_SY, P_AR2};
    exp_lens  = {12, 3, 2, 8, 3, 2};
    check_runs("side_svc");

    // Pedestrian priority, then the still-pending side request.
    do_reset();
    start_log();
    step(0, 0, 0);
    step(0, 1, 1);
    idle(55);
    exp_codes = {P_MG, P_MY, P_AR1, P_WALK, P_AR2, P_MG, P_MY, P_AR1, P_SG};
    exp_lens  = {12, 3, 2, 6, 2, 12, 3, 2, 8};
    check_runs("ped_prio");

    // Late request at timer 11 adds one main-green cycle.
    do_reset();
    start_log();
    idle(11);
    step(0, 1, 0);
    idle(8);
    exp_codes = {P_MG, P_MY};
    exp_lens  = {13, 3};
    check_runs("late_req");

    // Request at timer 3 still gets the full 12-cycle minimum green.
    do_reset();
    start_log();
    idle(3);
    step(0, 1, 0);
    idle(16);
    exp_codes = {P_MG, P_MY};
    exp_lens  = {12, 3};
    check_runs("early_req");

    // Side input high only on the SG entry edge is absorbed.
    do_reset();
    step(0, 1, 0);
    run_until(P_AR1, 0, 0, "drop");
    step(0, 1, 0);
    check("drop_side_pending", 32'(side_pending), 32'd0);
    run_until(P_MG, MGT - 1, 0, "drop_back");
    idle(10);
    check("drop_no_reservice", 32'(phase), 32'd0);

    // Side input held through SG re-latches and earns a second side cycle.
    do_reset();
    step(0, 1, 0);
    run_until(P_AR1, 0, 0, "hold");
    for (int i = 0; i < SGT + 1; i++) step(0, 1, 0);
    check("hold_side_pending", 32'(side_pending), 32'd1);
    start_log();
    idle(35);
    exp_codes = {P_SY, P_AR2, P_MG, P_MY, P_AR1, P_SG};
    exp_lens  = {3, 2, 12, 3, 2, 8};
    check_runs("hold");

    // Reset in side green at timer 4 drops straight to main green.
    do_reset();
    step(0, 1, 0);
    run_until(P_SG, SGT - 1 - 3, 0, "midrst");
    step(0, 0, 1);
    check("midrst_ped_latched", 32'(ped_pending), 32'd1);
    step(1, 0, 0);
    check("midrst_phase", 32'(phase), 32'd0);
    check("midrst_main_green", 32'(main_green), 32'd1);
    check("midrst_side_red", 32'(side_red), 32'd1);
    check("midrst_pendings", 32'({side_pending, ped_pending}), 32'd0);
    step(0, 0, 0);
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
